// File: rtl/srl_ra_player.sv
// srl_ra_player: loads a word stream into an srl_ra table and replays it in load order onto a valid/ready stream
module srl_ra_player #(
   parameter int WIDTH     = 32,
   parameter int DEEP      = 32,
   parameter int DEEP_BITS = (DEEP < 32) ? 4 : (DEEP < 64) ? 5 : (DEEP < 128) ? 6 : 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DEEP_BITS-1:0] cfg_len,
   input  logic                 cfg_loop,
   input  logic                 play_start,
   input  logic                 play_stop,
   output logic                 busy,
   input  logic                 load_valid,
   input  logic [WIDTH-1:0]     load_data,
   output logic                 load_ready,
   output logic                 srl_we,
   output logic [WIDTH-1:0]     srl_data,
   output logic [DEEP_BITS-1:0] srl_addr,
   output logic                 srl_ce,
   output logic                 srl_rstq,
   input  logic [WIDTH-1:0]     srl_dataq,
   output logic                 m_valid,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_last,
   input  logic                 m_ready
);
   typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
   state_t state, state_nx;
   logic [DEEP_BITS-1:0] len_q;
   logic loop_q, stop_pend, start, issue, pass_end;
   assign start      = (state == IDLE) & play_start;
   assign issue      = (state == PLAY) & (~m_valid | m_ready);
   assign pass_end   = issue & (srl_addr == '0);
   assign busy       = state != IDLE;
   assign load_ready = (state == IDLE) & ~play_start;
   assign srl_we     = load_valid & load_ready;
   assign srl_data   = load_data;
   assign srl_ce     = issue;
   assign srl_rstq   = start;
   assign m_data     = srl_dataq;
   always_comb begin
      state_nx = state;
      if (start) state_nx = PLAY;
      if (pass_end & (~loop_q | stop_pend | play_stop)) state_nx = DRAIN;
      if ((state == DRAIN) & (~m_valid | m_ready)) state_nx = IDLE;
   end
   // the SRL read register only advances on issue, so a stalled beat stays stable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         srl_addr  <= '0;
         stop_pend <= 1'b0;
         len_q     <= '0;
         loop_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) begin
            len_q    <= cfg_len;
            loop_q   <= cfg_loop;
            srl_addr <= cfg_len;
         end else if (issue)
            srl_addr <= (srl_addr == '0) ? len_q : srl_addr - DEEP_BITS'(1);
         if (issue) begin
            m_valid <= 1'b1;
            m_last  <= srl_addr == '0;
         end else if (m_ready)
            m_valid <= 1'b0;
         stop_pend <= (state_nx == IDLE) ? 1'b0 : stop_pend | ((state == PLAY) & play_stop);
      end
   end
endmodule

// File: tb/tb_srl_ra_player.sv
// tb_srl_ra_player: directed scoreboard bench around srl_ra_player with a behavioural srl_ra table
module tb_srl_ra_player;
   localparam int WIDTH = 32, DEEP = 32, DB = 5;
   logic clk = 0, rst = 1;
   logic [DB-1:0] cfg_len = '0;
   logic cfg_loop = 0, play_start = 0, play_stop = 0, load_valid = 0, m_ready = 0;
   logic [WIDTH-1:0] load_data = '0;
   logic busy, load_ready, srl_we, srl_ce, srl_rstq, m_valid, m_last;
   logic [WIDTH-1:0] srl_data, srl_dataq = '0, m_data;
   logic [DB-1:0] srl_addr;
   logic [WIDTH-1:0] mem [DEEP];
   logic [WIDTH:0] exp_q [$];
   int n_cmp = 0, n_bad = 0;

   srl_ra_player #(.WIDTH(WIDTH), .DEEP(DEEP), .DEEP_BITS(DB)) dut (
      .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_loop(cfg_loop), .play_start(play_start),
      .play_stop(play_stop), .busy(busy), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .srl_we(srl_we), .srl_data(srl_data), .srl_addr(srl_addr),
      .srl_ce(srl_ce), .srl_rstq(srl_rstq), .srl_dataq(srl_dataq), .m_valid(m_valid),
      .m_data(m_data), .m_last(m_last), .m_ready(m_ready));

   always #5 clk = ~clk;

   // srl_ra model: shift on we, registered addressed read, not cleared by rst
   always @(posedge clk) begin
      if (srl_we) begin
         mem[0] <= srl_data;
         for (int i = 1; i < DEEP; i++) mem[i] <= mem[i-1];
      end
      if (srl_rstq) srl_dataq <= '0;
      else if (srl_ce) srl_dataq <= mem[srl_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && m_valid) begin
         if (exp_q.size() == 0) chk("unexpected_beat", {m_last, m_data}, '1);
         else begin
            chk(m_ready ? "beat" : "stall_hold", {m_last, m_data}, exp_q[0]);
            if (m_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] w);
      load_valid = 1; load_data = w;
      tick();
      load_valid = 0;
   endtask

   task automatic start(input logic [DB-1:0] len, input logic lp);
      cfg_len = len; cfg_loop = lp; play_start = 1;
      tick();
      play_start = 0;
   endtask

   task automatic push(input logic lst, input logic [WIDTH-1:0] d);
      exp_q.push_back({lst, d});
   endtask

   task automatic push_table();
      push(0, 32'h11); push(0, 32'h22); push(0, 32'h33); push(1, 32'h44);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 200) begin tick(); k++; end
      chk({name, "_idle_timeout"}, 64'(busy), 0);
      tick();
      chk({name, "_queue_drained"}, 64'(exp_q.size()), 0);
   endtask

   initial begin
      tick(); tick();
      chk("rst_busy", 64'(busy), 0);
      chk("rst_m_valid", 64'(m_valid), 0);
      chk("rst_m_last", 64'(m_last), 0);
      chk("rst_srl_addr", 64'(srl_addr), 0);
      rst = 0;
      tick();
      chk("idle_load_ready", 64'(load_ready), 1);
      load(32'h11); load(32'h22); load(32'h33); load(32'h44);
      // one-shot pass at full throughput
      m_ready = 1;
      push_table();
      start(3, 0);
      repeat (4) tick();
      chk("t1_last_beat_busy", 64'(busy), 1);
      chk("t1_last_beat_flags", {62'b0, m_valid, m_last}, 3);
      tick();
      chk("t1_busy_drop", 64'(busy), 0);
      chk("t1_valid_drop", 64'(m_valid), 0);
      wait_idle("t1");
      // backpressure 1010...
      push_table();
      start(3, 0);
      for (int i = 0; i < 20; i++) begin m_ready = ~i[0]; tick(); end
      m_ready = 1;
      wait_idle("t2");
      // loop with stop on 2nd beat of pass 2
      push_table(); push_table();
      start(3, 1);
      repeat (6) tick();
      play_stop = 1;
      tick();
      play_stop = 0;
      wait_idle("t3");
      // single-entry loop, 5 beats
      repeat (5) push(1, 32'h44);
      start(0, 1);
      repeat (4) tick();
      play_stop = 1;
      tick();
      play_stop = 0;
      wait_idle("t4");
      // start wins over a simultaneous load
      push_table();
      load_valid = 1; load_data = 32'h99; cfg_len = 3; cfg_loop = 0; play_start = 1;
      #1;
      chk("t5_load_ready", 64'(load_ready), 0);
      chk("t5_srl_we", 64'(srl_we), 0);
      tick();
      load_valid = 0; play_start = 0;
      chk("t5_busy", 64'(busy), 1);
      wait_idle("t5");
      // reset mid-play while a beat is stalled
      m_ready = 0;
      push(0, 32'h11);
      start(3, 1);
      tick(); tick();
      chk("t6_valid_before_rst", 64'(m_valid), 1);
      rst = 1;
      #1;
      chk("t6_rst_valid", 64'(m_valid), 0);
      chk("t6_rst_busy", 64'(busy), 0);
      exp_q.delete();
      tick();
      rst = 0; m_ready = 1;
      tick();
      push_table();
      start(3, 0);
      wait_idle("t6");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
